// File: rtl/spn_round_ctrl_pkg.sv
// Shared S-box package for the 16-bit SPN round controller.
// Provides the 4-bit S-box table and nibble-wise substitution, the nibble-matrix
// transpose permutation, the round count and the controller FSM state type.
// Optional feature macro: SPN_DECRYPT_EN adds the inverse S-box table and the
// inverse substitution function.
package spn_round_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SBOX_W = 4;
  localparam int unsigned ROUNDS = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StDone
  } state_e;

  localparam logic [SBOX_W-1:0] SBOX [16] = '{
    4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
    4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
  };

  function automatic logic [DATA_W-1:0] sbox_substitute(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    for (int i = 0; i < int'(DATA_W / SBOX_W); i++) begin
      y[i*SBOX_W +: SBOX_W] = SBOX[x[i*SBOX_W +: SBOX_W]];
    end
    return y;
  endfunction

  // Bit i moves to bit 4*(i mod 4) + (i div 4): a transpose of the 4x4 nibble
  // matrix, so the same function undoes itself.
  function automatic logic [DATA_W-1:0] spn_permute(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    for (int i = 0; i < int'(DATA_W); i++) begin
      y[4*(i%4) + i/4] = x[i];
    end
    return y;
  endfunction

`ifdef SPN_DECRYPT_EN
  localparam logic [SBOX_W-1:0] INV_SBOX [16] = '{
    4'hE, 4'h3, 4'h4, 4'h8, 4'h1, 4'hC, 4'hA, 4'hF,
    4'h7, 4'hD, 4'h9, 4'h6, 4'hB, 4'h2, 4'h0, 4'h5
  };

  function automatic logic [DATA_W-1:0] inv_sbox_substitute(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    for (int i = 0; i < int'(DATA_W / SBOX_W); i++) begin
      y[i*SBOX_W +: SBOX_W] = INV_SBOX[x[i*SBOX_W +: SBOX_W]];
    end
    return y;
  endfunction
`endif

endpackage

// File: rtl/spn_key_sched.sv
// Round-key extraction for the SPN controller.
// Round key r (1..4) is the 16-bit window key[35-4r : 20-4r].
// Ports: key (32-bit cipher key), round_idx (1..4), round_key (16-bit window,
// zero for out-of-range indices).
module spn_key_sched (
  input  logic [31:0] key,
  input  logic [2:0]  round_idx,
  output logic [15:0] round_key
);

  always_comb begin
    round_key = '0;
    unique case (round_idx)
      3'd1:    round_key = key[31:16];
      3'd2:    round_key = key[27:12];
      3'd3:    round_key = key[23:8];
      3'd4:    round_key = key[19:4];
      default: round_key = '0;
    endcase
  end

endmodule

// File: rtl/spn_round_ctrl.sv
// Three-round 16-bit SPN cipher controller, one round per cycle.
// Accepts a block in IDLE (in_valid/in_ready), runs three rounds in ROUND, then
// holds the result in DONE (out_valid/out_ready) until it is taken.
// Ports: clk, rst (synchronous, active high); in_valid/in_ready/in_data/in_key/
// in_mode request side; out_valid/out_ready/out_data result side; busy.
// Optional feature macro: SPN_DECRYPT_EN enables decryption when in_mode = 1;
// without it in_mode is ignored and every block is encrypted.
module spn_round_ctrl #(
  parameter int unsigned ROUNDS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [31:0] in_key,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  import spn_round_ctrl_pkg::*;

  localparam logic [1:0] LastRound = 2'(ROUNDS);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [31:0] key_q, key_d;

  logic [2:0]  ks_idx;
  logic [15:0] rk, k4;
  logic [15:0] enc_sub, enc_out, round_out;

  spn_key_sched u_ks_round (
    .key       (key_q),
    .round_idx (ks_idx),
    .round_key (rk)
  );

  // K4 is needed alongside the per-round key in the last encrypt round and the
  // first decrypt round.
  spn_key_sched u_ks_last (
    .key       (key_q),
    .round_idx (3'd4),
    .round_key (k4)
  );

  assign enc_sub = sbox_substitute(data_q ^ rk);
  assign enc_out = (cnt_q == LastRound) ? (enc_sub ^ k4) : spn_permute(enc_sub);

`ifdef SPN_DECRYPT_EN
  logic        mode_q, mode_d;
  logic [15:0] dec_in, dec_out;

  assign dec_in    = (cnt_q == 2'd1) ? (data_q ^ k4) : spn_permute(data_q);
  assign dec_out   = inv_sbox_substitute(dec_in) ^ rk;
  // Decrypt round d uses K3, K2, K1 in turn.
  assign ks_idx    = mode_q ? (3'd4 - {1'b0, cnt_q}) : {1'b0, cnt_q};
  assign round_out = mode_q ? dec_out : enc_out;
`else
  logic unused_mode;
  assign unused_mode = in_mode;
  assign ks_idx      = {1'b0, cnt_q};
  assign round_out   = enc_out;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    key_d   = key_q;
`ifdef SPN_DECRYPT_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRound;
          cnt_d   = 2'd1;
          data_d  = in_data;
          key_d   = in_key;
`ifdef SPN_DECRYPT_EN
          mode_d  = in_mode;
`endif
        end
      end
      StRound: begin
        data_d = round_out;
        // Counter saturates at the last round instead of wrapping.
        if (cnt_q == LastRound) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      key_q   <= '0;
`ifdef SPN_DECRYPT_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      key_q   <= key_d;
`ifdef SPN_DECRYPT_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = out_valid ? data_q : 16'h0000;

endmodule

// File: tb/tb_spn_round_ctrl.sv
// Self-checking bench for spn_round_ctrl: directed cases plus randomized blocks
// compared against a table-driven reference cipher.
module tb_spn_round_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [31:0] in_key;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SPN_DECRYPT_EN
  localparam bit DecEn = 1'b1;
`else
  localparam bit DecEn = 1'b0;
`endif

  spn_round_ctrl #(.ROUNDS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference cipher ----------------
  int sbox_tbl [16] = '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7};

  function automatic logic [15:0] m_rk(input logic [31:0] k, input int r);
    logic [31:0] s;
    s = k >> (20 - 4 * r);
    return s[15:0];
  endfunction

  function automatic logic [15:0] m_sub(input logic [15:0] x, input bit inv);
    logic [15:0] y = '0;
    for (int n = 0; n < 4; n++) begin
      int v = int'((x >> (4 * n)) & 16'hF);
      int o = 0;
      if (inv) begin
        for (int j = 0; j < 16; j++) if (sbox_tbl[j] == v) o = j;
      end else begin
        o = sbox_tbl[v];
      end
      y = y | (16'(o) << (4 * n));
    end
    return y;
  endfunction

  function automatic logic [15:0] m_perm(input logic [15:0] x);
    logic [15:0] y = '0;
    for (int i = 0; i < 16; i++) y[4 * (i % 4) + i / 4] = x[i];
    return y;
  endfunction

  function automatic logic [15:0] m_enc(input logic [15:0] p, input logic [31:0] k);
    logic [15:0] s = p;
    for (int r = 1; r <= 3; r++) begin
      s = m_sub(s ^ m_rk(k, r), 1'b0);
      s = (r < 3) ? m_perm(s) : (s ^ m_rk(k, 4));
    end
    return s;
  endfunction

  function automatic logic [15:0] m_dec(input logic [15:0] c, input logic [31:0] k);
    logic [15:0] s;
    s = m_sub(c ^ m_rk(k, 4), 1'b1) ^ m_rk(k, 3);
    s = m_sub(m_perm(s), 1'b1) ^ m_rk(k, 2);
    s = m_sub(m_perm(s), 1'b1) ^ m_rk(k, 1);
    return s;
  endfunction

  function automatic logic [15:0] m_ref(input logic [15:0] d, input logic [31:0] k, input bit m);
    return (DecEn && m) ? m_dec(d, k) : m_enc(d, k);
  endfunction

  // One complete transaction from IDLE; returns the result and the number of
  // edges from the transfer edge to out_valid.
  task automatic run_block(input logic [15:0] d, input logic [31:0] k, input bit m,
                           output logic [15:0] res, output int lat);
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd1);
    in_data  = d;
    in_key   = k;
    in_mode  = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_key   = $urandom;
    in_mode  = ~m;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_accept_valid", 32'(out_valid), 32'd0);
  endtask

  logic [15:0] res, res2, exp;
  logic [15:0] blk [4];
  logic [15:0] expq [$];
  int lat, cnt, cyc, ntx, nrx;
  int tx_cyc [4];
  bit acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; in_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Known-answer encrypt
    run_block(16'h1234, 32'hDEADBEEF, 1'b0, res, lat);
    check("kat_latency", 32'(lat), 32'd3);
    check("kat_data", 32'(res), 32'(m_enc(16'h1234, 32'hDEADBEEF)));

    // Mode 1: decrypt round trip, or ignored when decryption is not built
    run_block(res, 32'hDEADBEEF, 1'b1, res2, lat);
    check("mode1_latency", 32'(lat), 32'd3);
    if (DecEn) check("decrypt_roundtrip", 32'(res2), 32'h1234);
    else check("mode_ignored", 32'(res2), 32'(m_enc(res, 32'hDEADBEEF)));

    // Randomized blocks
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d = 16'($urandom);
      logic [31:0] k = $urandom;
      bit m = 1'($urandom_range(0, 1));
      run_block(d, k, m, res, lat);
      check("rand_latency", 32'(lat), 32'd3);
      check("rand_data", 32'(res), 32'(m_ref(d, k, m)));
    end

    // Hold the result in DONE for 10 cycles with an in_valid pulse in between
    @(negedge clk);
    in_data = 16'hBEEF; in_key = 32'h0F1E2D3C; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp = m_enc(16'hBEEF, 32'h0F1E2D3C);
    cnt = 0;
    while (!out_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check("stall_latency", 32'(cnt), 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 4);
      in_data  = 16'($urandom);
      in_key   = $urandom;
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(exp));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_release_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("stall_pulse_ignored", 32'(busy), 32'd0);

    // Reset mid-round discards the block
    @(negedge clk);
    in_data = 16'h5A5A; in_key = 32'h12345678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("midround_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("midrst_no_output", 32'(cnt), 32'd0);

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 4; i++) blk[i] = 16'($urandom);
    in_key = 32'hCAFEF00D; in_mode = 1'b0;
    @(negedge clk);
    in_data = blk[0]; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; ntx = 0; nrx = 0;
    while ((ntx < 4 || nrx < 4) && cyc < 60) begin
      if (cyc > 0) @(negedge clk);
      acc = 1'b0;
      if (out_valid) begin
        if (expq.size() > 0) check("b2b_data", 32'(out_data), 32'(expq.pop_front()));
        else check("b2b_unexpected", 32'(out_valid), 32'd0);
        nrx++;
      end
      if (in_ready && in_valid) begin
        tx_cyc[ntx] = cyc;
        expq.push_back(m_enc(blk[ntx], 32'hCAFEF00D));
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        ntx++;
        if (ntx < 4) in_data = blk[ntx];
        else in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_tx_count", 32'(ntx), 32'd4);
    check("b2b_rx_count", 32'(nrx), 32'd4);
    for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(tx_cyc[i] - tx_cyc[i-1]), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spn_round_ctrl.md
SPN_ROUND_CTRL -- requirements
Module: spn_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 3, number of cipher rounds; only 3 is supported.
REQ-002 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request carries a valid block.
REQ-005 SHALL have port in_ready, output, 1, controller can accept a block.
REQ-006 SHALL have port in_data, input, 16, plaintext or ciphertext block.
REQ-007 SHALL have port in_key, input, 32, cipher key.
REQ-008 SHALL have port in_mode, input, 1, 0 = encrypt, 1 = decrypt (see REQ-026).
REQ-009 SHALL have port out_valid, output, 1, result is available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port out_data, output, 16, result block.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, ROUND and DONE.
REQ-014 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid and in_ready are both high at a clock edge.
REQ-015 SHALL, on transfer, latch in_data, in_key and in_mode, set the round counter to 1, and enter ROUND.
REQ-016 SHALL, in ROUND, process one round per cycle and increment the counter each cycle.
- After round 3 it enters DONE, so out_valid rises on the 3rd edge after the transfer edge.
REQ-017 SHALL derive round keys as K_r = key[35-4r : 20-4r] for r = 1..4.
- K1 = key[31:16], K4 = key[19:4].
REQ-018 SHALL, when encrypting, perform rounds 1 and 2 as: XOR K_r, then S-box substitution of every nibble, then permutation.
- Round 3 is: XOR K3, then substitution, then XOR K4.
REQ-019 SHALL use the permutation bit i -> bit 4*(i mod 4) + (i div 4); this is a nibble-matrix transpose and is self-inverse.
REQ-020 SHALL, in DONE, hold out_valid high with out_data stable until a clock edge where out_ready is high, then return to IDLE.
REQ-021 SHALL keep in_ready low in DONE, even when out_ready is high; the minimum spacing is one block per 5 cycles.
REQ-022 SHALL ignore in_valid, in_data, in_key and in_mode while not in IDLE; they have no effect on the block in flight.
REQ-023 SHALL drive out_data to 16'h0000 whenever out_valid is low.
REQ-024 SHALL never let the round counter wrap; it is 2 bits and saturates at 3.

Reset
REQ-025 SHALL, when rst is high at a clock edge and regardless of state (including mid-round or in DONE):
- go to IDLE;
- set in_ready = 1, out_valid = 0, out_data = 16'h0000, busy = 0;
- clear the counter, data and key registers;
- discard any block in flight, producing no output for it.

Configuration
REQ-026 SHALL, with SPN_DECRYPT_EN defined, honour in_mode = 1 and decrypt.
- Round d1: XOR K4, inverse substitution, XOR K3.
- Round d2: permutation, inverse substitution, XOR K2.
- Round d3: permutation, inverse substitution, XOR K1.
- Latency is identical to encryption.
REQ-027 SHALL, without SPN_DECRYPT_EN, ignore in_mode and always encrypt; no inverse S-box logic is synthesized.

Structure
REQ-028 SHALL take SBOX, SBOX_W, DATA_W and sbox_substitute from the shared S-box package.
- The package also gains: the inverse table INV_SBOX and inverse function, under SPN_DECRYPT_EN; the permutation function; the ROUNDS constant; and the FSM state enum typedef.
REQ-029 SHALL place the key extraction of REQ-017 in a sub-module, spn_key_sched, with inputs key and round index and output round_key.

Verification
REQ-030 SHALL cover: rst held 1 cycle mid-ROUND -> next cycle IDLE, in_ready = 1, out_valid = 0, out_data = 16'h0000, and no result ever emitted.
REQ-031 SHALL cover: encrypt in_data = 16'h1234, in_key = 32'hDEADBEEF -> out_valid exactly 3 edges after the transfer, and out_data equal to the bench model.
REQ-032 SHALL cover: with SPN_DECRYPT_EN, decrypting the REQ-031 result with the same key -> out_data = 16'h1234.
REQ-033 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable throughout, in_ready = 0, and an in_valid pulse is ignored.
REQ-034 SHALL cover: back-to-back requests with in_valid held 1 and out_ready held 1 -> transfers spaced exactly 5 cycles, with results in order.
REQ-035 SHALL cover: without SPN_DECRYPT_EN, in_mode = 1 -> result identical to in_mode = 0 for the same data and key.
